// File: rtl/serial_cmp_pkg.sv
// Shared types and limits for the serial comparator driver and its shift registers.
package serial_cmp_pkg;

    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RESULT = 3'd4
    } state_t;

endpackage

// File: rtl/serial_piso.sv
// Parallel-load, MSB-first shift register; msb always presents the next bit to send.
module serial_piso
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data;

    // load has priority so a fresh operand is never mixed with a partial shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data <= '0;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= data << 1;
        end
    end

    assign msb = data[WIDTH-1];

endmodule

// File: rtl/serial_compare_driver.sv
// Feeds two operands MSB-first into a serial magnitude comparator and returns its flags
// through a valid/ready result port.
module serial_compare_driver
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ser_a,
    output logic             ser_b,
    output logic             cmp_reset_bar,
    input  logic             cmp_gd,
    input  logic             cmp_ed,
    input  logic             cmp_ld,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_gt,
    output logic             res_eq,
    output logic             res_lt,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             shift_en;
    logic             msb_a;
    logic             msb_b;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);
    assign accept   = in_valid && (state == ST_IDLE);
    // CLEAR already pops the first bit so SHIFT starts with the MSB on the wire
    assign shift_en = (state == ST_CLEAR) || ((state == ST_SHIFT) && (cnt != '0));

    serial_piso #(.WIDTH(WIDTH)) u_piso_a (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .din   (op_a),
        .msb   (msb_a)
    );

    serial_piso #(.WIDTH(WIDTH)) u_piso_b (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .shift (shift_en),
        .din   (op_b),
        .msb   (msb_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            ser_a         <= 1'b0;
            ser_b         <= 1'b0;
            cmp_reset_bar <= 1'b0;
            res_valid     <= 1'b0;
            res_gt        <= 1'b0;
            res_eq        <= 1'b0;
            res_lt        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cmp_reset_bar <= 1'b1;
                    if (in_valid) begin
                        cnt           <= CNT_W'(WIDTH - 1);
                        cmp_reset_bar <= 1'b0;
                        ser_a         <= 1'b0;
                        ser_b         <= 1'b0;
                        state         <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    cmp_reset_bar <= 1'b1;
                    ser_a         <= msb_a;
                    ser_b         <= msb_b;
                    state         <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (cnt == '0) begin
                        ser_a <= 1'b0;
                        ser_b <= 1'b0;
                        state <= ST_SETTLE;
                    end else begin
                        ser_a <= msb_a;
                        ser_b <= msb_b;
                        cnt   <= cnt - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    res_gt    <= cmp_gd;
                    res_eq    <= cmp_ed;
                    res_lt    <= cmp_ld;
                    res_valid <= 1'b1;
                    state     <= ST_RESULT;
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_driver.sv
// Bench: drives 4-bit and 8-bit drivers, each wired to a behavioural serial comparator,
// and checks serial streams and results against integer comparison of the operands.
module tb_serial_compare_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-bit instance
    logic       in_valid = 1'b0, in_ready, res_ready = 1'b1;
    logic [3:0] op_a = '0, op_b = '0;
    logic       ser_a, ser_b, crb, gd, ed, ld;
    logic       res_valid, res_gt, res_eq, res_lt, busy;

    // 8-bit instance
    logic       in_valid8 = 1'b0, in_ready8, res_ready8 = 1'b1;
    logic [7:0] op_a8 = '0, op_b8 = '0;
    logic       ser_a8, ser_b8, crb8, gd8, ed8, ld8;
    logic       res_valid8, res_gt8, res_eq8, res_lt8, busy8;

    serial_compare_driver #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ser_a(ser_a), .ser_b(ser_b), .cmp_reset_bar(crb),
        .cmp_gd(gd), .cmp_ed(ed), .cmp_ld(ld), .res_valid(res_valid), .res_ready(res_ready),
        .res_gt(res_gt), .res_eq(res_eq), .res_lt(res_lt), .busy(busy)
    );

    serial_compare_driver #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .op_a(op_a8), .op_b(op_b8), .ser_a(ser_a8), .ser_b(ser_b8), .cmp_reset_bar(crb8),
        .cmp_gd(gd8), .cmp_ed(ed8), .cmp_ld(ld8), .res_valid(res_valid8), .res_ready(res_ready8),
        .res_gt(res_gt8), .res_eq(res_eq8), .res_lt(res_lt8), .busy(busy8)
    );

    // Serial comparator: clear to "equal", first differing bit decides and then sticks
    always @(posedge clk) begin
        if (!crb) begin
            gd <= 1'b0; ed <= 1'b1; ld <= 1'b0;
        end else if (ed && (ser_a != ser_b)) begin
            gd <= ser_a; ld <= ser_b; ed <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (!crb8) begin
            gd8 <= 1'b0; ed8 <= 1'b1; ld8 <= 1'b0;
        end else if (ed8 && (ser_a8 != ser_b8)) begin
            gd8 <= ser_a8; ld8 <= ser_b8; ed8 <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full 4-bit transaction; hold = cycles res_ready stays low while new operands are offered
    task automatic do_compare(input logic [3:0] a, input logic [3:0] b, input int hold);
        logic [3:0] sa, sb;
        logic [2:0] exp_flags;
        int crb_low;
        exp_flags = {a > b, a == b, a < b};
        in_valid = 1'b1; op_a = a; op_b = b; res_ready = 1'b1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL idle_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0; op_a = 4'($urandom); op_b = 4'($urandom);
        crb_low = (crb === 1'b0) ? 1 : 0;
        total++;
        if ({busy, in_ready} !== 2'b10) begin
            bad++; $display("FAIL accept_state: busy,in_ready got %b want 10", {busy, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            sa[3-i] = ser_a; sb[3-i] = ser_b;
            if (crb === 1'b0) crb_low++;
        end
        total++;
        if ({sa, sb} !== {a, b}) begin
            bad++; $display("FAIL ser_seq: a,b got %b/%b want %b/%b", sa, sb, a, b);
        end
        tick();
        if (crb === 1'b0) crb_low++;
        total++;
        if ({ser_a, ser_b, res_valid} !== 3'b000) begin
            bad++; $display("FAIL settle: ser_a,ser_b,res_valid got %b want 000", {ser_a, ser_b, res_valid});
        end
        tick();
        total++;
        if ({res_valid, res_gt, res_eq, res_lt} !== {1'b1, exp_flags}) begin
            bad++; $display("FAIL result: a=%h b=%h got v/gt/eq/lt %b want %b", a, b,
                            {res_valid, res_gt, res_eq, res_lt}, {1'b1, exp_flags});
        end
        total++;
        if (crb_low != 1) begin
            bad++; $display("FAIL clear_pulse: cycles low got %0d want 1", crb_low);
        end
        for (int h = 0; h < hold; h++) begin
            res_ready = 1'b0; in_valid = 1'b1; op_a = 4'($urandom); op_b = 4'($urandom);
            tick();
            total++;
            if ({res_valid, res_gt, res_eq, res_lt, in_ready, busy} !== {1'b1, exp_flags, 1'b0, 1'b1}) begin
                bad++; $display("FAIL hold: v/flags/in_ready/busy got %b want %b",
                                {res_valid, res_gt, res_eq, res_lt, in_ready, busy},
                                {1'b1, exp_flags, 1'b0, 1'b1});
            end
        end
        in_valid = 1'b0; res_ready = 1'b1;
        tick();
        total++;
        if ({res_valid, in_ready, busy, res_gt, res_eq, res_lt} !== {3'b010, exp_flags}) begin
            bad++; $display("FAIL handshake: v/in_ready/busy/flags got %b want %b",
                            {res_valid, in_ready, busy, res_gt, res_eq, res_lt}, {3'b010, exp_flags});
        end
    endtask

    task automatic do_compare8(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] sa, sb;
        logic [2:0] exp_flags;
        int busy_cnt, crb_low;
        exp_flags = {a > b, a == b, a < b};
        in_valid8 = 1'b1; op_a8 = a; op_b8 = b; res_ready8 = 1'b1;
        total++;
        if (in_ready8 !== 1'b1) begin
            bad++; $display("FAIL idle_ready8: got %b want 1", in_ready8);
        end
        tick();
        in_valid8 = 1'b0; op_a8 = 8'($urandom); op_b8 = 8'($urandom);
        busy_cnt = (busy8 === 1'b1 && res_valid8 === 1'b0) ? 1 : 0;
        crb_low  = (crb8 === 1'b0) ? 1 : 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i < 8) begin
                sa[7-i] = ser_a8; sb[7-i] = ser_b8;
            end
            if (busy8 === 1'b1 && res_valid8 === 1'b0) busy_cnt++;
            if (crb8 === 1'b0) crb_low++;
        end
        total++;
        if ({sa, sb} !== {a, b} || crb_low != 1) begin
            bad++; $display("FAIL ser_seq8: got %h/%h clr=%0d want %h/%h clr=1", sa, sb, crb_low, a, b);
        end
        tick();
        total++;
        if (busy_cnt != 10 || {res_valid8, res_gt8, res_eq8, res_lt8} !== {1'b1, exp_flags}) begin
            bad++; $display("FAIL result8: busy=%0d v/flags %b want busy=10 %b", busy_cnt,
                            {res_valid8, res_gt8, res_eq8, res_lt8}, {1'b1, exp_flags});
        end
        tick();
        total++;
        if ({res_valid8, in_ready8, busy8} !== 3'b010) begin
            bad++; $display("FAIL handshake8: got %b want 010", {res_valid8, in_ready8, busy8});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        total++;
        if ({ser_a, ser_b, crb, res_valid, res_gt, res_eq, res_lt, in_ready, busy} !== 9'b000000010) begin
            bad++; $display("FAIL reset4: got %b want 000000010",
                            {ser_a, ser_b, crb, res_valid, res_gt, res_eq, res_lt, in_ready, busy});
        end
        total++;
        if ({ser_a8, ser_b8, crb8, res_valid8, res_gt8, res_eq8, res_lt8, in_ready8, busy8} !== 9'b000000010) begin
            bad++; $display("FAIL reset8: got %b want 000000010",
                            {ser_a8, ser_b8, crb8, res_valid8, res_gt8, res_eq8, res_lt8, in_ready8, busy8});
        end
        reset = 1'b0;
        tick();
        total++;
        if ({crb, crb8} !== 2'b11) begin
            bad++; $display("FAIL release_clear: got %b want 11", {crb, crb8});
        end
    endtask

    task automatic test_lt();
        do_compare(4'b1010, 4'b1110, 0);
    endtask

    task automatic test_back_to_back();
        do_compare(4'b1111, 4'b1110, 0);
        do_compare(4'b0110, 4'b0111, 0);
    endtask

    task automatic test_eq();
        do_compare(4'b1011, 4'b1011, 0);
    endtask

    task automatic test_width8();
        do_compare8(8'h99, 8'h7F);
        do_compare8(8'h3C, 8'h3C);
    endtask

    task automatic test_hold();
        do_compare(4'b0101, 4'b1001, 5);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; op_a = 4'b1100; op_b = 4'b0101;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 reset = 1'b1;
        #1;
        total++;
        if ({ser_a, ser_b, crb, res_valid, res_gt, res_eq, res_lt, in_ready, busy} !== 9'b000000010) begin
            bad++; $display("FAIL reset_mid: got %b want 000000010",
                            {ser_a, ser_b, crb, res_valid, res_gt, res_eq, res_lt, in_ready, busy});
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if ({res_valid, in_ready, crb} !== 3'b011) begin
                bad++; $display("FAIL post_reset_idle: v/in_ready/crb got %b want 011", {res_valid, in_ready, crb});
            end
        end
        do_compare(4'b0001, 4'b0010, 0);
    endtask

    task automatic test_random();
        logic [3:0] a, b;
        for (int n = 0; n < 16; n++) begin
            a = 4'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 4'($urandom);
            do_compare(a, b, int'($urandom_range(0, 2)));
        end
        for (int n = 0; n < 4; n++) begin
            do_compare8(8'($urandom), 8'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_lt();
        test_back_to_back();
        test_eq();
        test_width8();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
